cim_burst_reader: RTL and testbench
===================================

# cim_burst_reader

Receiving end of the cascaded-integrator-multiplexor shift-out chain. Captures each `nchan`-word burst presented on `sr_out`/`sr_val` and applies the per-channel double difference (comb stage) that completes the CIC decimator. Publishes finished sets to a host-readable double buffer with a ready/ack handshake. Sits between the monitor chain and the local-bus register decoder.

## Interface
- `dw`, 32: word width; must equal the chain's `dw`.
- `nchan`, 12: words per burst.
- `aw`, 4: host address width; requires 2^aw ≥ nchan.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `sr_in`  in  dw  burst data (chain `sr_out`).
- `sr_val`  in  1  burst gate (chain `sr_val`).
- `host_addr`  in  aw  channel index into the published set.
- `host_data`  out  dw  comb result for `host_addr`; signed, registered.
- `rdy`  out  1  published set unread.
- `ack`  in  1  single-cycle host release of the published set.
- `overrun`  out  1  sticky: a completed set was discarded because `rdy` was high.
- `frame_err`  out  1  sticky: `sr_val` dropped mid-burst.
- `seq`  out  8  count of published sets, mod 256.

## Operation
- Word counter `idx` (0..nchan-1) advances on each cycle with `sr_val`=1. Word `idx` belongs to channel `idx`. The burst completes on the cycle with `sr_val`=1 and `idx`=nchan-1, and `idx` then returns to 0.
- Per channel, history registers `h1` (x[n-1]) and `h2` (x[n-2]) are kept.
  - Result: y = x - 2·h1 + h2, computed modulo 2^dw, no saturation. This is correct for wrapped integrators.
  - On each word: `h2`←`h1` and `h1`←x.
- Priming counter `primed` runs 0..2 and increments on each completed burst, saturating at 2.
  - A completed burst publishes only if `primed` was already 2 when its first word arrived. Earlier bursts update history only.
- Results are written into the back buffer at address `idx`. The front buffer is read by the host.
- On completion with publish eligibility:
  - `rdy`=0, or `ack` in the same cycle: swap front/back, set `rdy`=1, increment `seq`.
  - `rdy`=1 with no `ack`: discard the back buffer and set `overrun`=1. Front buffer, `rdy` and `seq` are unchanged.
- `ack` clears `rdy` and `overrun`. `ack` while `rdy`=0 is ignored, but still clears `overrun`.
- Framing error: `sr_val`=0 while 0 < `idx` < nchan.
  - Set `frame_err`, reset `idx` to 0 and `primed` to 0.
  - Partially written history is discarded logically: two full bursts are needed to re-prime.
  - `frame_err` is cleared by `rst` only.
- `host_addr` ≥ nchan returns 0.
- Reset clears `idx`, `primed`, all history, both buffers, the buffer select, `rdy`, `overrun`, `frame_err` and `seq`. `host_data`=0. Reset mid-burst abandons the burst without setting `frame_err`.

## Timing
- The comb pipeline has 2 stages: word at cycle t is written into the back buffer by the end of t+2.
- Last word of a burst at cycle T: swap, `rdy`=1 and `seq` update are visible at T+3. `overrun` is likewise visible at T+3.
- A new burst may begin at T+1. The back buffer is free for writes because the swap precedes the first write landing at T+3.
- `ack` in cycle A: `rdy`=0 at A+1. When A coincides with the internal completion cycle (T+2), the swap wins: `rdy` stays 1 with new data and `seq`+1.
- `host_data` is valid one cycle after `host_addr`, from whichever buffer is front at that cycle.
- Back-to-back bursts are allowed with no idle cycle between them.

## Test plan
- **Quadratic ramp:** after reset, send bursts n=0..3 with word k = (k+1)·n². `rdy` rises at T+3 of burst 2 only; `seq`=1; `host_data` at k reads 2·(k+1). After `ack` and burst 3, the values are the same and `seq`=2.
- **Wrap arithmetic:** channel 0 sequence 0x7FFFFFFE, 0x7FFFFFFF, 0x80000001 → `host_data`[0]=0x00000001.
- **Overrun:** publish one set and withhold `ack`; the next burst completes → `rdy`=1, `overrun`=1, front contents and `seq` unchanged. `ack` → both `rdy` and `overrun` are 0.
- **Coincident ack:** `rdy`=1; pulse `ack` exactly at T+2 of the next burst → `rdy` remains 1, new data, `seq` incremented, `overrun`=0.
- **Framing gap:** drop `sr_val` at word 5 → `frame_err`=1. The next two full bursts do not assert `rdy`; the third publishes correct differences of bursts 2–4 of the new run.
- **Reset mid-burst:** `rst` at word 6 → all outputs 0, `frame_err`=0. Recovery requires three further bursts to publish.

Source files
------------

// File: rtl/cim_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : cim_burst_reader
// Brief    : Captures CIC shift-out bursts, applies the per-channel double
//            difference and publishes finished sets through a double buffer.
// Revision : 1.0 - initial release
// ============================================================================
module cim_burst_reader #(
    parameter int dw    = 32,
    parameter int nchan = 12,
    parameter int aw    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [dw-1:0] sr_in,
    input  logic          sr_val,
    input  logic [aw-1:0] host_addr,
    output logic [dw-1:0] host_data,
    output logic          rdy,
    input  logic          ack,
    output logic          overrun,
    output logic          frame_err,
    output logic [7:0]    seq
);

    localparam int              c_iw   = (nchan > 1) ? $clog2(nchan) : 1;
    localparam logic [c_iw-1:0] c_last = c_iw'(nchan - 1);

    // Capture side: word counter, priming and per-channel history
    logic [c_iw-1:0] r_idx;
    logic [1:0]      r_primed;
    logic            r_burst_pub;
    logic            r_frame_err;
    logic [dw-1:0]   r_h1 [nchan];
    logic [dw-1:0]   r_h2 [nchan];

    // Comb pipeline
    logic            r_s1_val, r_s1_last, r_s1_pub;
    logic [c_iw-1:0] r_s1_idx;
    logic [dw-1:0]   r_s1_x, r_s1_h1, r_s1_h2;
    logic            r_s2_val, r_s2_last, r_s2_pub;
    logic [c_iw-1:0] r_s2_idx;
    logic [dw-1:0]   r_s2_y;

    // Publication side
    logic [dw-1:0]   r_buf [2][nchan];
    logic            r_front;
    logic            r_rdy;
    logic            r_overrun;
    logic [7:0]      r_seq;
    logic [dw-1:0]   r_host_data;

    logic            w_last;
    logic            w_pub;
    logic            w_complete;
    logic            w_addr_ok;
    logic [c_iw-1:0] w_rd_idx;
    logic            w_back;

    assign w_last     = sr_val && (r_idx == c_last);
    // Eligibility is frozen when the first word arrives, not at completion
    assign w_pub      = (r_idx == '0) ? (r_primed == 2'd2) : r_burst_pub;
    assign w_complete = r_s2_val && r_s2_last && r_s2_pub;
    assign w_addr_ok  = (32'(host_addr) < 32'(nchan));
    assign w_rd_idx   = c_iw'(host_addr);
    assign w_back     = ~r_front;

    always_ff @(posedge clk) begin : p_capture
        if (rst) begin
            r_idx       <= '0;
            r_primed    <= '0;
            r_burst_pub <= 1'b0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < nchan; i++) begin
                r_h1[i] <= '0;
                r_h2[i] <= '0;
            end
        end else if (sr_val) begin
            r_h1[r_idx] <= sr_in;
            r_h2[r_idx] <= r_h1[r_idx];
            if (r_idx == '0) begin
                r_burst_pub <= (r_primed == 2'd2);
            end
            if (w_last) begin
                r_idx    <= '0;
                r_primed <= (r_primed == 2'd2) ? 2'd2 : r_primed + 2'd1;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else if (r_idx != '0) begin
            // Gap inside a burst: history is now inconsistent, so re-prime
            r_idx       <= '0;
            r_primed    <= '0;
            r_frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin : p_comb_pipe
        if (rst) begin
            r_s1_val  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_pub  <= 1'b0;
            r_s1_idx  <= '0;
            r_s1_x    <= '0;
            r_s1_h1   <= '0;
            r_s1_h2   <= '0;
            r_s2_val  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_pub  <= 1'b0;
            r_s2_idx  <= '0;
            r_s2_y    <= '0;
        end else begin
            r_s1_val  <= sr_val;
            r_s1_last <= w_last;
            r_s1_pub  <= w_pub;
            r_s1_idx  <= r_idx;
            r_s1_x    <= sr_in;
            r_s1_h1   <= r_h1[r_idx];
            r_s1_h2   <= r_h2[r_idx];
            r_s2_val  <= r_s1_val;
            r_s2_last <= r_s1_last;
            r_s2_pub  <= r_s1_pub;
            r_s2_idx  <= r_s1_idx;
            r_s2_y    <= r_s1_x - (r_s1_h1 << 1) + r_s1_h2;
        end
    end

    always_ff @(posedge clk) begin : p_publish
        if (rst) begin
            r_front   <= 1'b0;
            r_rdy     <= 1'b0;
            r_overrun <= 1'b0;
            r_seq     <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < nchan; i++) begin
                    r_buf[b][i] <= '0;
                end
            end
        end else begin
            if (r_s2_val) begin
                r_buf[w_back][r_s2_idx] <= r_s2_y;
            end
            if (ack) begin
                r_overrun <= 1'b0;
            end
            // A swap in the ack cycle takes precedence over the release
            if (w_complete && (!r_rdy || ack)) begin
                r_front <= w_back;
                r_rdy   <= 1'b1;
                r_seq   <= r_seq + 8'd1;
            end else begin
                if (w_complete) begin
                    r_overrun <= 1'b1;
                end
                if (ack) begin
                    r_rdy <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin : p_host_read
        if (rst) begin
            r_host_data <= '0;
        end else begin
            r_host_data <= w_addr_ok ? r_buf[r_front][w_rd_idx] : '0;
        end
    end

    assign host_data = r_host_data;
    assign rdy       = r_rdy;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign seq       = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_cim_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cim_burst_reader
// Brief    : Directed + randomized bench for cim_burst_reader with a set-level
//            reference model (last three full bursts per channel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cim_burst_reader;

    localparam int c_dw  = 32;
    localparam int c_nch = 12;
    localparam int c_aw  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [c_dw-1:0]   sr_in = '0;
    logic              sr_val = 1'b0;
    logic [c_aw-1:0]   host_addr = '0;
    logic [c_dw-1:0]   host_data;
    logic              rdy;
    logic              ack = 1'b0;
    logic              overrun;
    logic              frame_err;
    logic [7:0]        seq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: burst values, previous two full bursts, published set
    logic [c_dw-1:0] cur     [c_nch];
    logic [c_dw-1:0] p1      [c_nch];
    logic [c_dw-1:0] p2      [c_nch];
    logic [c_dw-1:0] m_front [c_nch];
    int              run_n;
    logic            m_rdy, m_ovr, m_ferr;
    logic [7:0]      m_seq;

    cim_burst_reader #(.dw(c_dw), .nchan(c_nch), .aw(c_aw)) dut (
        .clk       (clk),
        .rst       (rst),
        .sr_in     (sr_in),
        .sr_val    (sr_val),
        .host_addr (host_addr),
        .host_data (host_data),
        .rdy       (rdy),
        .ack       (ack),
        .overrun   (overrun),
        .frame_err (frame_err),
        .seq       (seq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [c_dw-1:0] obs, input logic [c_dw-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        run_n  = 0;
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_seq  = '0;
        for (int k = 0; k < c_nch; k++) begin
            m_front[k] = '0;
            p1[k] = '0;
            p2[k] = '0;
        end
    endtask

    // Effect of a completed full burst held in cur[]
    task automatic model_complete(input bit ack_now);
        logic [c_dw-1:0] y [c_nch];
        if (ack_now) m_ovr = 1'b0;
        if (run_n >= 2) begin
            for (int k = 0; k < c_nch; k++) y[k] = cur[k] - (p1[k] << 1) + p2[k];
            if (!m_rdy || ack_now) begin
                for (int k = 0; k < c_nch; k++) m_front[k] = y[k];
                m_rdy = 1'b1;
                m_seq = m_seq + 8'd1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (ack_now) begin
            m_rdy = 1'b0;
        end
        for (int k = 0; k < c_nch; k++) begin
            p2[k] = p1[k];
            p1[k] = cur[k];
        end
        run_n++;
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".rdy"}, {31'b0, rdy}, {31'b0, m_rdy});
        chk({tag, ".overrun"}, {31'b0, overrun}, {31'b0, m_ovr});
        chk({tag, ".seq"}, {24'b0, seq}, {24'b0, m_seq});
        chk({tag, ".frame_err"}, {31'b0, frame_err}, {31'b0, m_ferr});
    endtask

    task automatic read_set(input string tag);
        for (int k = 0; k <= c_nch; k++) begin
            host_addr = c_aw'(k);
            tick();
            chk($sformatf("%s.data[%0d]", tag, k), host_data, (k < c_nch) ? m_front[k] : '0);
        end
        host_addr = 4'hF;
        tick();
        chk({tag, ".data[15]"}, host_data, '0);
    endtask

    // Drive cur[] as a burst; stop_at >= 0 aborts at that word (gap or reset)
    task automatic send_burst(input int stop_at, input bit use_rst);
        for (int k = 0; k < c_nch; k++) begin
            if (k == stop_at) begin
                sr_val = use_rst;
                sr_in  = cur[k];
                rst    = use_rst;
                tick();
                rst    = 1'b0;
                sr_val = 1'b0;
                return;
            end
            sr_in  = cur[k];
            sr_val = 1'b1;
            tick();
        end
        sr_val = 1'b0;
    endtask

    // Called right after the last word's edge; observes rdy at T+2 and T+3
    task automatic finish(input string tag, input bit ack_t2);
        tick();
        chk({tag, ".rdy_t2"}, {31'b0, rdy}, {31'b0, m_rdy});
        ack = ack_t2;
        tick();
        ack = 1'b0;
        model_complete(ack_t2);
        check_status(tag);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        chk({tag, ".rdy"}, {31'b0, rdy}, 32'd0);
        chk({tag, ".overrun"}, {31'b0, overrun}, 32'd0);
    endtask

    task automatic fill_ramp(input int n);
        for (int k = 0; k < c_nch; k++) cur[k] = c_dw'((k + 1) * n * n);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < c_nch; k++) cur[k] = $urandom;
    endtask

    initial begin
        model_clear();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_status("reset");
        chk("reset.host_data", host_data, '0);

        // Quadratic ramp: bursts 0 and 1 back-to-back, then 2 publishes
        fill_ramp(0);
        send_burst(-1, 1'b0);
        model_complete(1'b0);
        fill_ramp(1);
        send_burst(-1, 1'b0);
        finish("ramp1", 1'b0);
        fill_ramp(2);
        send_burst(-1, 1'b0);
        finish("ramp2", 1'b0);
        read_set("ramp2");
        do_ack("ramp_ack");
        fill_ramp(3);
        send_burst(-1, 1'b0);
        finish("ramp3", 1'b0);
        read_set("ramp3");

        // Wrap arithmetic on channel 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        fill_rand(); cur[0] = 32'h7FFF_FFFE; send_burst(-1, 1'b0); finish("wrap0", 1'b0);
        fill_rand(); cur[0] = 32'h7FFF_FFFF; send_burst(-1, 1'b0); finish("wrap1", 1'b0);
        fill_rand(); cur[0] = 32'h8000_0001; send_burst(-1, 1'b0); finish("wrap2", 1'b0);
        host_addr = '0;
        tick();
        chk("wrap.ch0", host_data, 32'h0000_0001);
        read_set("wrap");

        // Overrun: withhold ack across the next completion
        fill_rand();
        send_burst(-1, 1'b0);
        finish("overrun", 1'b0);
        read_set("overrun");
        do_ack("overrun_ack");

        // Coincident ack at T+2 of the following burst
        fill_rand(); send_burst(-1, 1'b0); finish("coin_pre", 1'b0);
        fill_rand(); send_burst(-1, 1'b0); finish("coin", 1'b1);
        read_set("coin");
        do_ack("coin_ack");

        // Framing gap at word 5, then three full bursts
        fill_rand();
        send_burst(5, 1'b0);
        run_n  = 0;
        m_ferr = 1'b1;
        chk("gap.frame_err", {31'b0, frame_err}, 32'd1);
        for (int b = 0; b < 3; b++) begin
            fill_rand();
            send_burst(-1, 1'b0);
            finish($sformatf("gap_b%0d", b), 1'b0);
        end
        read_set("gap");

        // Reset at word 6 of a burst
        fill_rand();
        send_burst(6, 1'b1);
        model_clear();
        check_status("rst_mid");
        chk("rst_mid.host_data", host_data, '0);
        for (int b = 0; b < 3; b++) begin
            fill_rand();
            send_burst(-1, 1'b0);
            finish($sformatf("rec_b%0d", b), 1'b0);
        end
        read_set("rec");
        do_ack("rec_ack");

        // Random back-to-back bursts without ack: first publishes, rest overrun
        for (int b = 0; b < 5; b++) begin
            fill_rand();
            send_burst(-1, 1'b0);
            model_complete(1'b0);
        end
        tick();
        tick();
        check_status("b2b");
        read_set("b2b");
        do_ack("b2b_ack");
        fill_rand();
        send_burst(-1, 1'b0);
        finish("b2b_last", 1'b0);
        read_set("b2b_last");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
